rally_ctrl: RTL and testbench

RALLY_CTRL -- requirements
Module: rally_ctrl

---
 rtl/rally_ctrl_pkg.sv | 36 +++
 rtl/rally_ctrl_cycle_timer.sv | 29 ++
 rtl/rally_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_rally_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rally_ctrl_pkg.sv
// Shared game definitions for the rally controller: FSM encoding, player ids,
// court geometry and small score/position helpers.
package rally_ctrl_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        RALLY = 2'd1,
        POINT = 2'd2,
        OVER  = 2'd3
    } rally_state_e;

    localparam logic PLAYER1 = 1'b0;
    localparam logic PLAYER2 = 1'b1;

    localparam int unsigned NET_X     = 512;
    localparam int unsigned BALL_HALF = 32;

    localparam int unsigned POSX_W   = 12;
    localparam int unsigned CENTER_W = 13;
    localparam int unsigned SCORE_W  = 4;

    localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(15);

    // Score increment that holds at the 4-bit ceiling.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
    endfunction

    // Ball landing on the left half of the court is a point for PLAYER2.
    function automatic logic ground_winner(input logic [POSX_W-1:0] posx);
        logic [CENTER_W-1:0] center;
        center = CENTER_W'(posx) + CENTER_W'(BALL_HALF);
        return (center < CENTER_W'(NET_X)) ? PLAYER2 : PLAYER1;
    endfunction

endpackage

// File: rtl/rally_ctrl_cycle_timer.sv
// Loadable down-counter that saturates at zero; done_c is high while the count is zero.
module cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/rally_ctrl.sv
// Volleyball rally referee: counts touches per side, scores ground contacts and
// touch-limit faults, holds after each point and detects the end of the match.
module rally_ctrl
    import rally_ctrl_pkg::*;
#(
    parameter int unsigned MAX_TOUCH  = 3,
    parameter int unsigned GHOST_CYC  = 16_250_000,
    parameter int unsigned POINT_HOLD = 162_500_000,
    parameter int unsigned WIN_SCORE  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pl1_col,
    input  logic               pl2_col,
    input  logic               gnd_col,
    input  logic [POSX_W-1:0]  ball_posx,
    input  logic               new_game,
    output logic               ovr_touch,
    output logic               last_touch,
    output logic [SCORE_W-1:0] pl1_score,
    output logic [SCORE_W-1:0] pl2_score,
    output logic [1:0]         rally_state,
    output logic               game_over,
    output logic               winner
);

    localparam int unsigned GHOST_W = $clog2(GHOST_CYC + 2);
    localparam int unsigned HOLD_W  = $clog2(POINT_HOLD + 2);
    localparam int unsigned CNT_W   = $clog2(MAX_TOUCH + 2);

    localparam logic [GHOST_W-1:0] GHOST_LOAD = GHOST_W'(GHOST_CYC);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(POINT_HOLD - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_TOUCH);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    rally_state_e state_q, state_d;

    logic pl1_q, pl2_q, gnd_q;
    logic pl1_rise_c, pl2_rise_c, gnd_rise_c;
    logic ghost_done_c, hold_done_c;
    logic touch_ok_c, toucher_c, touch_fault_c, game_won_c;

    logic [CNT_W-1:0]   pl1_cnt_q, pl2_cnt_q, pl1_cnt_d, pl2_cnt_d;
    logic [SCORE_W-1:0] pl1_score_d, pl2_score_d;
    logic               last_touch_d, ovr_touch_d, game_over_d, winner_d;
    logic               ghost_load_c, hold_load_c, timer_clear_c;
    logic               award_c, award_to_c;

    assign pl1_rise_c = pl1_col & ~pl1_q;
    assign pl2_rise_c = pl2_col & ~pl2_q;
    assign gnd_rise_c = gnd_col & ~gnd_q;

    // A touch only counts outside the ghost window; pl1 wins a simultaneous rise.
    assign touch_ok_c    = ghost_done_c & (pl1_rise_c | pl2_rise_c);
    assign toucher_c     = pl1_rise_c ? PLAYER1 : PLAYER2;
    assign touch_fault_c = (toucher_c == PLAYER1) ? (pl1_cnt_q == CNT_MAX)
                                                  : (pl2_cnt_q == CNT_MAX);
    assign game_won_c    = (pl1_score == WIN_VAL) || (pl2_score == WIN_VAL);

    cycle_timer #(.WIDTH(GHOST_W)) u_ghost (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear_c),
        .load     (ghost_load_c),
        .load_val (GHOST_LOAD),
        .done_c   (ghost_done_c)
    );

    cycle_timer #(.WIDTH(HOLD_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear_c),
        .load     (hold_load_c),
        .load_val (HOLD_LOAD),
        .done_c   (hold_done_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SERVE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = SERVE;
        end else begin
            case (state_q)
                SERVE: if (touch_ok_c) state_d = RALLY;
                RALLY: if (gnd_rise_c || (touch_ok_c && touch_fault_c)) state_d = POINT;
                POINT: if (hold_done_c) state_d = game_won_c ? OVER : SERVE;
                OVER:  state_d = OVER;
                default: state_d = SERVE;
            endcase
        end
    end

    // Next values of the touch counters, scores and registered outputs.
    always_comb begin
        pl1_cnt_d     = pl1_cnt_q;
        pl2_cnt_d     = pl2_cnt_q;
        pl1_score_d   = pl1_score;
        pl2_score_d   = pl2_score;
        last_touch_d  = last_touch;
        ovr_touch_d   = 1'b0;
        ghost_load_c  = 1'b0;
        hold_load_c   = 1'b0;
        timer_clear_c = 1'b0;
        award_c       = 1'b0;
        award_to_c    = PLAYER1;

        if (new_game) begin
            pl1_cnt_d     = '0;
            pl2_cnt_d     = '0;
            pl1_score_d   = '0;
            pl2_score_d   = '0;
            last_touch_d  = PLAYER1;
            timer_clear_c = 1'b1;
        end else begin
            case (state_q)
                SERVE: begin
                    if (touch_ok_c) begin
                        ghost_load_c = 1'b1;
                        pl1_cnt_d    = (toucher_c == PLAYER1) ? CNT_W'(1) : '0;
                        pl2_cnt_d    = (toucher_c == PLAYER2) ? CNT_W'(1) : '0;
                    end
                end
                RALLY: begin
                    if (gnd_rise_c) begin
                        award_c    = 1'b1;
                        award_to_c = ground_winner(ball_posx);
                    end else if (touch_ok_c) begin
                        ghost_load_c = 1'b1;
                        if (touch_fault_c) begin
                            ovr_touch_d = 1'b1;
                            award_c     = 1'b1;
                            award_to_c  = ~toucher_c;
                        end else if (toucher_c == PLAYER1) begin
                            pl1_cnt_d = pl1_cnt_q + CNT_W'(1);
                            pl2_cnt_d = '0;
                        end else begin
                            pl2_cnt_d = pl2_cnt_q + CNT_W'(1);
                            pl1_cnt_d = '0;
                        end
                    end
                end
                POINT: begin
                    if (hold_done_c && !game_won_c) begin
                        pl1_cnt_d = '0;
                        pl2_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end

        if (award_c) begin
            hold_load_c  = 1'b1;
            last_touch_d = award_to_c;
            if (award_to_c == PLAYER1) begin
                pl1_score_d = score_inc(pl1_score);
            end else begin
                pl2_score_d = score_inc(pl2_score);
            end
        end

        game_over_d = (state_d == OVER);
        winner_d    = (state_d == OVER) ? last_touch_d : PLAYER1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pl1_q      <= 1'b0;
            pl2_q      <= 1'b0;
            gnd_q      <= 1'b0;
            pl1_cnt_q  <= '0;
            pl2_cnt_q  <= '0;
            pl1_score  <= '0;
            pl2_score  <= '0;
            last_touch <= PLAYER1;
            ovr_touch  <= 1'b0;
            game_over  <= 1'b0;
            winner     <= PLAYER1;
        end else begin
            pl1_q      <= pl1_col;
            pl2_q      <= pl2_col;
            gnd_q      <= gnd_col;
            pl1_cnt_q  <= pl1_cnt_d;
            pl2_cnt_q  <= pl2_cnt_d;
            pl1_score  <= pl1_score_d;
            pl2_score  <= pl2_score_d;
            last_touch <= last_touch_d;
            ovr_touch  <= ovr_touch_d;
            game_over  <= game_over_d;
            winner     <= winner_d;
        end
    end

    assign rally_state = state_q;

endmodule

// File: tb/tb_rally_ctrl.sv
// Directed bench for rally_ctrl with shortened ghost/hold windows.
module tb_rally_ctrl;

    localparam int unsigned MT = 3;
    localparam int unsigned GC = 4;
    localparam int unsigned PH = 6;
    localparam int unsigned WS = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pl1_col = 1'b0;
    logic        pl2_col = 1'b0;
    logic        gnd_col = 1'b0;
    logic [11:0] ball_posx = 12'd0;
    logic        new_game = 1'b0;
    logic        ovr_touch, last_touch, game_over, winner;
    logic [3:0]  pl1_score, pl2_score;
    logic [1:0]  rally_state;

    int passed = 0;
    int total  = 0;

    rally_ctrl #(
        .MAX_TOUCH  (MT),
        .GHOST_CYC  (GC),
        .POINT_HOLD (PH),
        .WIN_SCORE  (WS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pl1_col     (pl1_col),
        .pl2_col     (pl2_col),
        .gnd_col     (gnd_col),
        .ball_posx   (ball_posx),
        .new_game    (new_game),
        .ovr_touch   (ovr_touch),
        .last_touch  (last_touch),
        .pl1_score   (pl1_score),
        .pl2_score   (pl2_score),
        .rally_state (rally_state),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit p1, input bit p2, input bit g);
        pl1_col = p1;
        pl2_col = p2;
        gnd_col = g;
        step(1);
        pl1_col = 1'b0;
        pl2_col = 1'b0;
        gnd_col = 1'b0;
    endtask

    // pl1 serves, ball lands on the chosen side, then the hold runs out.
    task automatic play_point(input bit p2_wins);
        pulse(1, 0, 0);
        ball_posx = p2_wins ? 12'd400 : 12'd700;
        pulse(0, 0, 1);
        step(PH);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(2);
        total++; if (rally_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", rally_state); else passed++;
        total++; if (pl1_score !== 4'd0 || pl2_score !== 4'd0) $display("FAIL reset_scores got=%0d/%0d exp=0/0", pl1_score, pl2_score); else passed++;
        total++; if ({ovr_touch, last_touch, game_over, winner} !== 4'b0) $display("FAIL reset_flags got=%b exp=0000", {ovr_touch, last_touch, game_over, winner}); else passed++;
        rst = 1'b1;
        step(1);
        total++; if (rally_state !== 2'd0) $display("FAIL reset_release_state got=%0d exp=0", rally_state); else passed++;
    endtask

    task automatic test_serve_ground();
        ball_posx = 12'd700;
        pulse(0, 0, 1);
        total++; if (rally_state !== 2'd0 || pl1_score !== 4'd0) $display("FAIL serve_gnd_ignored got=%0d/%0d exp=0/0", rally_state, pl1_score); else passed++;
        pulse(1, 0, 0);
        total++; if (rally_state !== 2'd1) $display("FAIL serve_touch_state got=%0d exp=1", rally_state); else passed++;
        pulse(0, 0, 1);
        total++; if (rally_state !== 2'd2) $display("FAIL gnd700_state got=%0d exp=2", rally_state); else passed++;
        total++; if (pl1_score !== 4'd1 || pl2_score !== 4'd0 || last_touch !== 1'b0) $display("FAIL gnd700_score got=%0d/%0d lt=%b exp=1/0 lt=0", pl1_score, pl2_score, last_touch); else passed++;
        step(PH - 1);
        total++; if (rally_state !== 2'd2) $display("FAIL hold_last_cycle got=%0d exp=2", rally_state); else passed++;
        step(1);
        total++; if (rally_state !== 2'd0) $display("FAIL hold_done_serve got=%0d exp=0", rally_state); else passed++;
    endtask

    task automatic test_over_touch();
        for (int i = 0; i < 3; i++) begin
            pulse(0, 1, 0);
            total++; if (ovr_touch !== 1'b0 || rally_state !== 2'd1) $display("FAIL pl2_touch%0d ovr=%b st=%0d exp=0/1", i + 1, ovr_touch, rally_state); else passed++;
            step(GC);
        end
        pulse(0, 1, 0);
        total++; if (ovr_touch !== 1'b1 || rally_state !== 2'd2) $display("FAIL pl2_touch4 ovr=%b st=%0d exp=1/2", ovr_touch, rally_state); else passed++;
        total++; if (pl1_score !== 4'd2 || pl2_score !== 4'd0 || last_touch !== 1'b0) $display("FAIL overtouch_score got=%0d/%0d lt=%b exp=2/0 lt=0", pl1_score, pl2_score, last_touch); else passed++;
        step(1);
        total++; if (ovr_touch !== 1'b0) $display("FAIL ovr_pulse_width got=%b exp=0", ovr_touch); else passed++;
        step(PH - 1);
        total++; if (rally_state !== 2'd0) $display("FAIL overtouch_back_serve got=%0d exp=0", rally_state); else passed++;
    endtask

    task automatic test_ghost_window();
        pulse(1, 0, 0);
        step(1);
        pulse(1, 0, 0);
        total++; if (rally_state !== 2'd1 || ovr_touch !== 1'b0) $display("FAIL ghost_second st=%0d ovr=%b exp=1/0", rally_state, ovr_touch); else passed++;
        step(GC);
        for (int i = 0; i < 2; i++) begin
            pulse(1, 0, 0);
            total++; if (ovr_touch !== 1'b0) $display("FAIL ghost_follow%0d ovr=%b exp=0", i + 2, ovr_touch); else passed++;
            step(GC);
        end
        pulse(1, 0, 0);
        total++; if (ovr_touch !== 1'b1 || pl2_score !== 4'd1 || last_touch !== 1'b1) $display("FAIL ghost_fault ovr=%b p2=%0d lt=%b exp=1/1/1", ovr_touch, pl2_score, last_touch); else passed++;
        step(PH);
    endtask

    task automatic test_gnd_priority();
        pulse(1, 0, 0);
        step(GC);
        ball_posx = 12'd400;
        pulse(0, 1, 1);
        total++; if (rally_state !== 2'd2 || ovr_touch !== 1'b0) $display("FAIL gnd_prio st=%0d ovr=%b exp=2/0", rally_state, ovr_touch); else passed++;
        total++; if (pl1_score !== 4'd2 || pl2_score !== 4'd2 || last_touch !== 1'b1) $display("FAIL gnd_prio_score got=%0d/%0d lt=%b exp=2/2 lt=1", pl1_score, pl2_score, last_touch); else passed++;
        step(PH);
    endtask

    task automatic test_center_boundary();
        pulse(1, 0, 0);
        ball_posx = 12'd479;
        pulse(0, 0, 1);
        total++; if (pl2_score !== 4'd3 || last_touch !== 1'b1) $display("FAIL center511 p2=%0d lt=%b exp=3/1", pl2_score, last_touch); else passed++;
        step(PH);
        pulse(1, 0, 0);
        ball_posx = 12'd480;
        pulse(0, 0, 1);
        total++; if (pl1_score !== 4'd3 || last_touch !== 1'b0) $display("FAIL center512 p1=%0d lt=%b exp=3/0", pl1_score, last_touch); else passed++;
        step(PH);
    endtask

    task automatic test_simultaneous();
        pulse(1, 1, 0);
        total++; if (rally_state !== 2'd1) $display("FAIL simul_state got=%0d exp=1", rally_state); else passed++;
        step(GC);
        pulse(1, 0, 0);
        step(GC);
        pulse(1, 0, 0);
        total++; if (ovr_touch !== 1'b0) $display("FAIL simul_third ovr=%b exp=0", ovr_touch); else passed++;
        step(GC);
        pulse(1, 0, 0);
        total++; if (ovr_touch !== 1'b1 || pl2_score !== 4'd4) $display("FAIL simul_fault ovr=%b p2=%0d exp=1/4", ovr_touch, pl2_score); else passed++;
        step(PH);
    endtask

    task automatic test_win();
        new_game = 1'b1;
        step(1);
        new_game = 1'b0;
        total++; if (pl1_score !== 4'd0 || pl2_score !== 4'd0 || rally_state !== 2'd0) $display("FAIL newgame_serve got=%0d/%0d st=%0d exp=0/0/0", pl1_score, pl2_score, rally_state); else passed++;
        for (int i = 0; i < 14; i++) play_point(1);
        total++; if (pl2_score !== 4'd14 || pl1_score !== 4'd0 || rally_state !== 2'd0) $display("FAIL at14 got=%0d/%0d st=%0d exp=0/14/0", pl1_score, pl2_score, rally_state); else passed++;
        pulse(1, 0, 0);
        ball_posx = 12'd400;
        pulse(0, 0, 1);
        total++; if (pl2_score !== 4'd15 || last_touch !== 1'b1 || game_over !== 1'b0) $display("FAIL win_point p2=%0d lt=%b go=%b exp=15/1/0", pl2_score, last_touch, game_over); else passed++;
        step(PH);
        total++; if (rally_state !== 2'd3 || game_over !== 1'b1 || winner !== 1'b1) $display("FAIL over st=%0d go=%b win=%b exp=3/1/1", rally_state, game_over, winner); else passed++;
        pulse(1, 1, 1);
        step(2);
        total++; if (rally_state !== 2'd3 || pl2_score !== 4'd15 || pl1_score !== 4'd0) $display("FAIL over_ignores st=%0d p=%0d/%0d exp=3/0/15", rally_state, pl1_score, pl2_score); else passed++;
        new_game = 1'b1;
        step(1);
        new_game = 1'b0;
        total++; if (rally_state !== 2'd0 || pl1_score !== 4'd0 || pl2_score !== 4'd0) $display("FAIL restart st=%0d p=%0d/%0d exp=0/0/0", rally_state, pl1_score, pl2_score); else passed++;
        total++; if ({last_touch, game_over, winner} !== 3'b000) $display("FAIL restart_flags got=%b exp=000", {last_touch, game_over, winner}); else passed++;
    endtask

    task automatic test_new_game_mid();
        play_point(0);
        pulse(1, 0, 0);
        new_game = 1'b1;
        step(1);
        new_game = 1'b0;
        total++; if (rally_state !== 2'd0 || pl1_score !== 4'd0) $display("FAIL newgame_mid st=%0d p1=%0d exp=0/0", rally_state, pl1_score); else passed++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) play_point(0);
        play_point(1);
        pulse(1, 0, 0);
        total++; if (rally_state !== 2'd1 || pl1_score !== 4'd3 || last_touch !== 1'b1) $display("FAIL pre_reset st=%0d p1=%0d lt=%b exp=1/3/1", rally_state, pl1_score, last_touch); else passed++;
        #2;
        rst = 1'b0;
        #1;
        total++; if (rally_state !== 2'd0 || pl1_score !== 4'd0 || pl2_score !== 4'd0) $display("FAIL async_reset st=%0d p=%0d/%0d exp=0/0/0", rally_state, pl1_score, pl2_score); else passed++;
        total++; if ({ovr_touch, last_touch, game_over, winner} !== 4'b0) $display("FAIL async_reset_flags got=%b exp=0000", {ovr_touch, last_touch, game_over, winner}); else passed++;
        #2;
        rst = 1'b1;
        ball_posx = 12'd700;
        pulse(0, 0, 1);
        step(1);
        total++; if (rally_state !== 2'd0 || pl1_score !== 4'd0) $display("FAIL post_reset st=%0d p1=%0d exp=0/0", rally_state, pl1_score); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_serve_ground();
        test_over_touch();
        test_ghost_window();
        test_gnd_priority();
        test_center_boundary();
        test_simultaneous();
        test_win();
        test_new_game_mid();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
